// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package countdown_timer_pkg;

  localparam int CDT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer_if.sv
// Load handshake, control levels and status outputs of the countdown timer.
interface countdown_timer_if
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = CDT_WIDTH
);

  logic             io_load_valid;
  logic             io_load_ready;
  logic [WIDTH-1:0] io_load_payload;
  logic             io_autoReload;
  logic             io_pause;
  logic             io_clear;
  logic [WIDTH-1:0] io_value;
  logic             io_busy;
  logic             io_done;

  modport master (
    output io_load_valid,
    output io_load_payload,
    output io_autoReload,
    output io_pause,
    output io_clear,
    input  io_load_ready,
    input  io_value,
    input  io_busy,
    input  io_done
  );

  modport slave (
    input  io_load_valid,
    input  io_load_payload,
    input  io_autoReload,
    input  io_pause,
    input  io_clear,
    output io_load_ready,
    output io_value,
    output io_busy,
    output io_done
  );

endinterface : countdown_timer_if

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle expiry pulse and optional auto-reload.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = CDT_WIDTH
) (
  input logic              clk,
  input logic              reset,
  countdown_timer_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             load_fire;

  // Decrement that can never wrap below zero.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - WIDTH'(1);
  endfunction

  assign load_fire = bus.io_load_valid && (state_q == IDLE) && !bus.io_clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      value_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (bus.io_clear) begin
      state_d = IDLE;
      value_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_fire) begin
            if (bus.io_load_payload != '0) begin
              value_d  = bus.io_load_payload;
              reload_d = bus.io_load_payload;
              state_d  = RUN;
            end else begin
              // A zero load expires immediately without ever entering RUN.
              value_d = '0;
              done_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (!bus.io_pause) begin
            if (value_q > WIDTH'(1)) begin
              value_d = sat_dec(value_q);
            end else begin
              done_d = 1'b1;
              if (bus.io_autoReload) begin
                value_d = reload_q;
              end else begin
                value_d = '0;
                state_d = IDLE;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          value_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.io_load_ready = (state_q == IDLE) && !bus.io_clear;
    bus.io_busy       = (state_q == RUN);
    bus.io_value      = value_q;
    bus.io_done       = done_q;
  end

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one-shot, auto-reload, pause, zero load, clear and reset.
module tb_countdown_timer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  countdown_timer_if #(.WIDTH(8)) bus ();

  countdown_timer #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++; if (bus.io_value !== 8'd0) begin n_fail++; $display("FAIL reset_value got=%0d exp=0", bus.io_value); end
    n_checks++; if (bus.io_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.io_done); end
    n_checks++; if (bus.io_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.io_busy); end
    n_checks++; if (bus.io_load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.io_load_ready); end
    step();
    n_checks++; if (bus.io_load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got=%b exp=1", bus.io_load_ready); end
  endtask

  task automatic test_one_shot();
    bus.io_load_payload = 8'd5;
    bus.io_load_valid   = 1'b1;
    step();
    bus.io_load_valid = 1'b0;
    n_checks++; if (bus.io_value !== 8'd5) begin n_fail++; $display("FAIL one_shot_load got=%0d exp=5", bus.io_value); end
    n_checks++; if (bus.io_load_ready !== 1'b0) begin n_fail++; $display("FAIL one_shot_ready0 got=%b exp=0", bus.io_load_ready); end
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++; if (bus.io_value !== 8'(5 - k)) begin n_fail++; $display("FAIL one_shot_value k=%0d got=%0d exp=%0d", k, bus.io_value, 5 - k); end
      n_checks++; if (bus.io_done !== (k == 5)) begin n_fail++; $display("FAIL one_shot_done k=%0d got=%b exp=%b", k, bus.io_done, k == 5); end
      n_checks++; if (bus.io_busy !== (k < 5)) begin n_fail++; $display("FAIL one_shot_busy k=%0d got=%b exp=%b", k, bus.io_busy, k < 5); end
      n_checks++; if (bus.io_load_ready !== (k == 5)) begin n_fail++; $display("FAIL one_shot_ready k=%0d got=%b exp=%b", k, bus.io_load_ready, k == 5); end
    end
    step();
    n_checks++; if (bus.io_done !== 1'b0) begin n_fail++; $display("FAIL one_shot_done_drop got=%b exp=0", bus.io_done); end
  endtask

  task automatic test_auto_reload();
    bus.io_autoReload   = 1'b1;
    bus.io_load_payload = 8'd3;
    bus.io_load_valid   = 1'b1;
    step();
    // Valid held high during RUN with a different payload must be ignored.
    bus.io_load_payload = 8'd7;
    n_checks++; if (bus.io_value !== 8'd3) begin n_fail++; $display("FAIL auto_load got=%0d exp=3", bus.io_value); end
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++; if (bus.io_value !== 8'((k % 3 == 0) ? 3 : 3 - (k % 3))) begin n_fail++; $display("FAIL auto_value k=%0d got=%0d exp=%0d", k, bus.io_value, (k % 3 == 0) ? 3 : 3 - (k % 3)); end
      n_checks++; if (bus.io_done !== (k % 3 == 0)) begin n_fail++; $display("FAIL auto_done k=%0d got=%b exp=%b", k, bus.io_done, k % 3 == 0); end
      n_checks++; if (bus.io_busy !== 1'b1) begin n_fail++; $display("FAIL auto_busy k=%0d got=%b exp=1", k, bus.io_busy); end
    end
    bus.io_load_valid = 1'b0;
    bus.io_clear      = 1'b1;
    #1;
    n_checks++; if (bus.io_load_ready !== 1'b0) begin n_fail++; $display("FAIL auto_clear_ready got=%b exp=0", bus.io_load_ready); end
    step();
    bus.io_clear      = 1'b0;
    bus.io_autoReload = 1'b0;
    n_checks++; if (bus.io_value !== 8'd0) begin n_fail++; $display("FAIL auto_clear_value got=%0d exp=0", bus.io_value); end
    n_checks++; if (bus.io_busy !== 1'b0) begin n_fail++; $display("FAIL auto_clear_busy got=%b exp=0", bus.io_busy); end
    n_checks++; if (bus.io_done !== 1'b0) begin n_fail++; $display("FAIL auto_clear_done got=%b exp=0", bus.io_done); end
  endtask

  task automatic test_pause();
    logic [7:0] exp_v [7];
    exp_v = '{8'd4, 8'd3, 8'd2, 8'd2, 8'd2, 8'd1, 8'd0};
    bus.io_load_payload = 8'd4;
    bus.io_load_valid   = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      bus.io_load_valid = 1'b0;
      bus.io_pause      = (k == 2 || k == 3);
      n_checks++; if (bus.io_value !== exp_v[k]) begin n_fail++; $display("FAIL pause_value k=%0d got=%0d exp=%0d", k, bus.io_value, exp_v[k]); end
      n_checks++; if (bus.io_done !== (k == 6)) begin n_fail++; $display("FAIL pause_done k=%0d got=%b exp=%b", k, bus.io_done, k == 6); end
    end
    bus.io_pause = 1'b0;
  endtask

  task automatic test_pause_terminal();
    logic [7:0] exp_v [5];
    exp_v = '{8'd2, 8'd1, 8'd1, 8'd1, 8'd0};
    bus.io_load_payload = 8'd2;
    bus.io_load_valid   = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      step();
      bus.io_load_valid = 1'b0;
      bus.io_pause      = (k == 1 || k == 2);
      n_checks++; if (bus.io_value !== exp_v[k]) begin n_fail++; $display("FAIL pterm_value k=%0d got=%0d exp=%0d", k, bus.io_value, exp_v[k]); end
      n_checks++; if (bus.io_done !== (k == 4)) begin n_fail++; $display("FAIL pterm_done k=%0d got=%b exp=%b", k, bus.io_done, k == 4); end
      n_checks++; if (bus.io_busy !== (k < 4)) begin n_fail++; $display("FAIL pterm_busy k=%0d got=%b exp=%b", k, bus.io_busy, k < 4); end
    end
    bus.io_pause = 1'b0;
  endtask

  task automatic test_zero_load();
    bus.io_load_payload = 8'd0;
    bus.io_load_valid   = 1'b1;
    step();
    bus.io_load_valid = 1'b0;
    n_checks++; if (bus.io_done !== 1'b1) begin n_fail++; $display("FAIL zero_done got=%b exp=1", bus.io_done); end
    n_checks++; if (bus.io_value !== 8'd0) begin n_fail++; $display("FAIL zero_value got=%0d exp=0", bus.io_value); end
    n_checks++; if (bus.io_busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got=%b exp=0", bus.io_busy); end
    n_checks++; if (bus.io_load_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got=%b exp=1", bus.io_load_ready); end
    step();
    n_checks++; if (bus.io_done !== 1'b0) begin n_fail++; $display("FAIL zero_done_drop got=%b exp=0", bus.io_done); end
    n_checks++; if (bus.io_busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after got=%b exp=0", bus.io_busy); end
  endtask

  task automatic test_clear_and_reload();
    bus.io_load_payload = 8'd255;
    bus.io_load_valid   = 1'b1;
    step();
    bus.io_load_valid = 1'b0;
    n_checks++; if (bus.io_value !== 8'd255) begin n_fail++; $display("FAIL max_load got=%0d exp=255", bus.io_value); end
    for (int k = 1; k <= 155; k++) begin
      step();
      n_checks++; if (bus.io_value !== 8'(255 - k) || bus.io_done !== 1'b0) begin n_fail++; $display("FAIL max_count k=%0d got=%0d/%b exp=%0d/0", k, bus.io_value, bus.io_done, 255 - k); end
    end
    bus.io_clear = 1'b1;
    step();
    bus.io_clear        = 1'b0;
    n_checks++; if (bus.io_value !== 8'd0) begin n_fail++; $display("FAIL clr100_value got=%0d exp=0", bus.io_value); end
    n_checks++; if (bus.io_busy !== 1'b0) begin n_fail++; $display("FAIL clr100_busy got=%b exp=0", bus.io_busy); end
    n_checks++; if (bus.io_done !== 1'b0) begin n_fail++; $display("FAIL clr100_done got=%b exp=0", bus.io_done); end
    bus.io_load_payload = 8'd2;
    bus.io_load_valid   = 1'b1;
    step();
    bus.io_load_valid = 1'b0;
    n_checks++; if (bus.io_value !== 8'd2) begin n_fail++; $display("FAIL reload2_value got=%0d exp=2", bus.io_value); end
    step();
    n_checks++; if (bus.io_value !== 8'd1 || bus.io_done !== 1'b0) begin n_fail++; $display("FAIL reload2_mid got=%0d/%b exp=1/0", bus.io_value, bus.io_done); end
    step();
    n_checks++; if (bus.io_value !== 8'd0 || bus.io_done !== 1'b1) begin n_fail++; $display("FAIL reload2_end got=%0d/%b exp=0/1", bus.io_value, bus.io_done); end
  endtask

  task automatic test_back_to_back();
    bus.io_load_payload = 8'd2;
    bus.io_load_valid   = 1'b1;
    step();
    bus.io_load_valid = 1'b0;
    step();
    step();
    n_checks++; if (bus.io_done !== 1'b1 || bus.io_load_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_end done/ready got=%b/%b exp=1/1", bus.io_done, bus.io_load_ready); end
    bus.io_load_payload = 8'd3;
    bus.io_load_valid   = 1'b1;
    step();
    bus.io_load_valid = 1'b0;
    n_checks++; if (bus.io_value !== 8'd3 || bus.io_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart value/busy got=%0d/%b exp=3/1", bus.io_value, bus.io_busy); end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++; if (bus.io_value !== 8'(3 - k) || bus.io_done !== (k == 3)) begin n_fail++; $display("FAIL b2b_run k=%0d got=%0d/%b exp=%0d/%b", k, bus.io_value, bus.io_done, 3 - k, k == 3); end
    end
  endtask

  task automatic test_abort();
    bus.io_load_payload = 8'd9;
    bus.io_load_valid   = 1'b1;
    step();
    bus.io_load_valid = 1'b0;
    step();
    step();
    n_checks++; if (bus.io_value !== 8'd7) begin n_fail++; $display("FAIL abort_pre_reset got=%0d exp=7", bus.io_value); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (bus.io_value !== 8'd0 || bus.io_busy !== 1'b0 || bus.io_done !== 1'b0) begin n_fail++; $display("FAIL abort_reset got=%0d/%b/%b exp=0/0/0", bus.io_value, bus.io_busy, bus.io_done); end
    step();
    n_checks++; if (bus.io_done !== 1'b0 || bus.io_load_ready !== 1'b1 || bus.io_value !== 8'd0) begin n_fail++; $display("FAIL abort_reset_after done/ready/value got=%b/%b/%0d exp=0/1/0", bus.io_done, bus.io_load_ready, bus.io_value); end
    bus.io_load_payload = 8'd2;
    bus.io_load_valid   = 1'b1;
    step();
    bus.io_load_valid = 1'b0;
    step();
    n_checks++; if (bus.io_value !== 8'd1) begin n_fail++; $display("FAIL abort_pre_clear got=%0d exp=1", bus.io_value); end
    bus.io_clear = 1'b1;
    step();
    bus.io_clear = 1'b0;
    n_checks++; if (bus.io_value !== 8'd0 || bus.io_busy !== 1'b0 || bus.io_done !== 1'b0) begin n_fail++; $display("FAIL abort_clear got=%0d/%b/%b exp=0/0/0", bus.io_value, bus.io_busy, bus.io_done); end
    step();
    n_checks++; if (bus.io_done !== 1'b0 || bus.io_load_ready !== 1'b1) begin n_fail++; $display("FAIL abort_clear_after done/ready got=%b/%b exp=0/1", bus.io_done, bus.io_load_ready); end
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    reset               = 1'b1;
    bus.io_load_valid   = 1'b0;
    bus.io_load_payload = 8'd0;
    bus.io_autoReload   = 1'b0;
    bus.io_pause        = 1'b0;
    bus.io_clear        = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_pause_terminal();
    test_zero_load();
    test_clear_and_reload();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter: the decrementing counterpart of the workshop up-counter. Accepts a start value over a valid/ready load handshake and counts it down to zero, one step per unpaused cycle. Emits a one-cycle done pulse at expiry and optionally auto-reloads for periodic ticks. It is a timeout/period generator for workshop designs that need "N cycles from now" rather than a free-running count.

## Interface
- WIDTH, 8, counter and load payload width (≥2)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; no asynchronous reset
- io_load_valid  in  1  start request
- io_load_ready  out  1  high only in IDLE (and not during io_clear)
- io_load_payload  in  WIDTH  start/reload value, unsigned
- io_autoReload  in  1  level, sampled at each terminal decrement
- io_pause  in  1  level; freezes the count while RUN
- io_clear  in  1  synchronous abort
- io_value  out  WIDTH  current count, registered
- io_busy  out  1  high in RUN
- io_done  out  1  registered one-cycle expiry pulse

## Operation
- States: IDLE, RUN. Registers: state, value, reloadReg (WIDTH), done.
- Reset: state=IDLE, io_value=0, reloadReg=0, io_done=0, io_busy=0, io_load_ready=1 (from the first cycle after reset deasserts).
- Priority per edge: reset > io_clear > load/count.
- io_clear: next state IDLE, value=0, done=0, no done pulse; ready forced low in the clear cycle.
- IDLE with fire (valid & ready):
  - payload≠0: value=payload, reloadReg=payload, go RUN.
  - payload=0: stay IDLE, value=0, done=1 next cycle (immediate expiry).
- IDLE without fire: hold value.
- RUN, io_pause=1: hold value and state; done=0.
- RUN, io_pause=0, value>1: value=value−1.
- RUN, io_pause=0, value=1 (terminal decrement): done=1 next cycle.
  - io_autoReload=1: value=reloadReg, stay RUN.
  - Otherwise: value=0, go IDLE.
- done is 0 in every cycle not following a terminal decrement or zero-load.
- Arithmetic: unsigned WIDTH-bit. value never wraps below 0. The max payload 2^WIDTH−1 is legal.
- io_load_valid in RUN is ignored; the payload is not captured. The requester must hold valid until ready.

## Timing
- Load of N≠0 accepted at edge 0: io_value=N after edge 0, N−k after edge k. After edge N: io_value=0, io_done=1, io_busy=0, io_load_ready=1.
- One-shot latency from accept to done: N cycles plus paused cycles.
- Auto-reload period: exactly N unpaused cycles between done pulses. io_value sequence N, N−1 … 1, N, …
- Back-to-back: a load accepted in the cycle io_done is high starts a new run with no gap cycle.
- Pause asserted in the terminal cycle (value=1) blocks expiry until released.
- io_clear in the same cycle as a terminal decrement: clear wins, no done.
- Reset asserted mid-run: reset values appear after that edge. The run is discarded.

## Structure
- Shared package: state enum {IDLE, RUN}, default WIDTH constant.
- Single module, no sub-module. The datapath is one decrementer plus a reload register.

## Test plan
- Load 5, no pause, autoReload=0 → io_value 5,4,3,2,1,0; io_done high exactly the cycle value becomes 0; ready low for 5 cycles.
- Load 3, autoReload=1 for 10 cycles → value 3,2,1,3,2,1,3…; done pulses every 3 cycles; busy stays high.
- Load 4, pause high for 2 cycles when value=2 → value holds 2 for 2 cycles; done arrives 6 cycles after accept.
- Load 0 → stays IDLE, io_done=1 one cycle later, io_value=0, busy never high.
- Load 255 (WIDTH=8), then clear at value=100 → value=0, IDLE, no done. Load 2 the next cycle → done after 2 cycles.
- Reset asserted mid-run at value=7 and clear coincident with value=1 → reset values after the edge; no done pulse in either case.
